// File: rtl/usb_fs_bulk_in_ep.sv
// Bulk IN endpoint adapter: buffers a user byte stream and hands it to the
// protocol engine's IN slot as packets of at most MAX_PKT bytes.
module usb_fs_bulk_in_ep #(
  parameter int MAX_PKT      = 32,
  parameter int DEPTH        = 64,
  parameter int FLUSH_CYCLES = 48000,
  parameter int ZLP_EN       = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       usb_reset,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic       flush,
  input  logic       stall,
  output logic       busy,
  output logic       in_ep_req,
  input  logic       in_ep_grant,
  input  logic       in_ep_data_free,
  output logic       in_ep_data_put,
  output logic [7:0] in_ep_data,
  output logic       in_ep_data_done,
  output logic       in_ep_stall,
  input  logic       in_ep_acked
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = $clog2(MAX_PKT + 1);
  localparam int TW = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_MAX   = CW'(MAX_PKT);
  localparam logic [LW-1:0] L_MAX   = LW'(MAX_PKT);
  localparam logic [TW-1:0] T_FLUSH = TW'(FLUSH_CYCLES);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_PUT, S_DONE, S_WAIT} state_t;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic [TW-1:0] r_timer;
  state_t        r_state;
  logic [LW-1:0] r_len, r_bcnt;
  logic          r_pend, r_zlp, r_req, r_put, r_done;
  logic [7:0]    r_data;

  logic          w_wr_acc, w_xfer_go, w_pop, w_timeout, w_send;
  logic [LW-1:0] w_len_next;

  assign wr_ready        = (r_count != C_DEPTH);
  assign busy            = (r_state != S_IDLE) || (r_count != '0);
  assign in_ep_req       = r_req;
  assign in_ep_data_put  = r_put;
  assign in_ep_data      = r_data;
  assign in_ep_data_done = r_done;
  assign in_ep_stall     = stall;

  assign w_wr_acc  = wr_valid && wr_ready;
  assign w_xfer_go = in_ep_grant && in_ep_data_free;
  // Pop exactly when the FSM below issues a put; both must agree.
  assign w_pop = !usb_reset &&
                 (((r_state == S_REQ) && w_xfer_go && (r_len != '0)) ||
                  ((r_state == S_PUT) && (r_bcnt != r_len) && in_ep_grant));
  assign w_timeout  = (FLUSH_CYCLES != 0) && (r_timer == T_FLUSH);
  assign w_send     = !stall && ((r_count >= C_MAX) || r_pend || w_timeout || r_zlp);
  assign w_len_next = r_zlp ? '0 : ((r_count >= C_MAX) ? L_MAX : LW'(r_count));

  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (usb_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + 1'b1;
      if (w_pop)    r_rptr <= r_rptr + 1'b1;
      case ({w_wr_acc, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  // Idle timer only runs while bytes sit in the FIFO with no new writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_timer <= '0;
    end else if (usb_reset) begin
      r_timer <= '0;
    end else if (w_wr_acc || (r_count == '0)) begin
      r_timer <= '0;
    end else if (r_timer != T_FLUSH) begin
      r_timer <= r_timer + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      r_bcnt  <= '0;
      r_pend  <= 1'b0;
      r_zlp   <= 1'b0;
      r_req   <= 1'b0;
      r_put   <= 1'b0;
      r_done  <= 1'b0;
      r_data  <= '0;
    end else if (usb_reset) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      r_bcnt  <= '0;
      r_pend  <= 1'b0;
      r_zlp   <= 1'b0;
      r_req   <= 1'b0;
      r_put   <= 1'b0;
      r_done  <= 1'b0;
      r_data  <= '0;
    end else begin
      if (flush && (r_count != '0)) r_pend <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_send) begin
            r_state <= S_REQ;
            r_req   <= 1'b1;
            r_len   <= w_len_next;
          end
        end
        S_REQ: begin
          if (w_xfer_go) begin
            r_state <= S_PUT;
            r_pend  <= 1'b0;
            if (r_len != '0) begin
              r_put  <= 1'b1;
              r_data <= r_mem[r_rptr];
              r_bcnt <= LW'(1);
            end else begin
              r_bcnt <= '0;
            end
          end
        end
        S_PUT: begin
          if (r_bcnt == r_len) begin
            r_state <= S_DONE;
            r_put   <= 1'b0;
            r_done  <= 1'b1;
          end else if (in_ep_grant) begin
            r_put  <= 1'b1;
            r_data <= r_mem[r_rptr];
            r_bcnt <= r_bcnt + 1'b1;
          end else begin
            r_put <= 1'b0;
          end
        end
        S_DONE: begin
          r_state <= S_WAIT;
          r_done  <= 1'b0;
          r_req   <= 1'b0;
        end
        S_WAIT: begin
          // A full packet that drained the FIFO must be followed by a ZLP.
          if (in_ep_acked) begin
            r_state <= S_IDLE;
            r_zlp   <= (ZLP_EN != 0) && (r_len == L_MAX) && (r_count == '0);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
